multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  EX-stage issuer for the MUL/DIV unit: detects MULT/MULTU/DIV/DIVU in EX, latches operands,
//  launches the unit, stalls the pipeline until completion and writes {HI,LO} back.
//  Sits between the EX-stage decode and the multi-cycle arithmetic unit. Handles exception
//  flush (abort) and a watchdog timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles before forced abort; must exceed divider latency (36)
//  CNT_W           7   watchdog counter width; requires 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  ex_valid     in   1   EX holds a valid instruction
//  ex_inst      in   8   EX instruction code (INST_* encoding)
//  ex_op1       in   32  rs operand
//  ex_op2       in   32  rt operand
//  flush        in   1   exception flush of EX and younger stages
//  stall_req    out  1   hold IF..EX this cycle (combinational)
//  mc_start     out  1   one-cycle launch pulse to unit (registered)
//  mc_inst      out  8   latched inst code to unit; INST_NOP when idle
//  mc_op1       out  32  latched operand 1
//  mc_op2       out  32  latched operand 2
//  mc_abort     out  1   one-cycle cancel pulse to unit (registered)
//  mc_done      in   1   unit result valid
//  mc_result    in   64  unit result {hi,lo}; div: {remainder,quotient}
//  hilo_we      out  1   HI/LO write enable (combinational)
//  hilo_wdata   out  64  HI/LO write data {hi,lo}
//  mc_timeout   out  1   one-cycle pulse on watchdog abort (registered)
// BEHAVIOUR
//  Reset: state IDLE, counter 0, mc_inst=INST_NOP, ops/hilo_wdata 0, all pulses 0.
//  is_mc = ex_inst in {INST_MULT, INST_MULTU, INST_DIV, INST_DIVU}.
//  launch = (state==IDLE) & ex_valid & is_mc & ~flush.
//  stall_req = launch | (state==WAIT). COMMIT does not stall (EX inst retires that cycle).
//  IDLE: launch -> latch ex_inst/ops, mc_start=1 next cycle, counter=0, go WAIT.
//        flush or non-mc inst: stay IDLE, no start. mc_done in IDLE ignored.
//  WAIT: counter +1 per cycle. Priority: flush > mc_done > timeout.
//        flush -> mc_abort=1 next cycle, go IDLE, no write (same cycle as mc_done: flush wins).
//        mc_done -> hilo_wdata<=mc_result, go COMMIT.
//        counter==TIMEOUT_CYCLES-1 and no done -> mc_abort=1, mc_timeout=1, go IDLE, no write.
//  COMMIT: hilo_we = ~flush (flush here squashes the write). Go IDLE unconditionally;
//        no relaunch from COMMIT, even if EX shows an mc inst (next inst is seen in IDLE).
//  mc_inst returns to INST_NOP on entry to IDLE so the unit never sees a stale request.
//  Latency: launch cycle L; mc_start at L+1; done at D >= L+1; hilo_we at D+1.
//  Back-to-back mc insts: second launches in the cycle after COMMIT; minimum spacing 3 cycles.
//  Async rst mid-operation: immediate return to IDLE, no hilo_we, no abort pulse
//  (the unit shares rst).
//  Operands/results passed verbatim; sign handling belongs to the unit.
// STRUCTURE
//  Shared defs header: INST_MULT/MULTU/DIV/DIVU/NOP codes (existing), state encodings
//  MC_IDLE/MC_WAIT/MC_COMMIT (2-bit).
//  Single module, no sub-modules; the watchdog counter is inline.
// TESTING
//  DIVU 100/7, done after 36 cyc -> stall_req high for 37 cyc,
//    hilo_we one cycle, hilo_wdata={32'd2,32'd14}.
//  MULT -3*5 with unit done next cycle -> mc_start 1 cycle, hilo_we at L+3,
//    hilo_wdata=64'hFFFFFFFF_FFFFFFF1.
//  flush at WAIT cycle 10 -> mc_abort pulse next cycle, stall_req drops, no hilo_we,
//    later mc_done ignored.
//  mc_done and flush same cycle -> abort, no write;
//    flush during COMMIT -> hilo_we stays 0.
//  mc_done never asserted -> mc_timeout and mc_abort after 64 WAIT cycles, state IDLE, no write.
//  DIV then DIVU back-to-back in EX -> two mc_start pulses, two hilo_we in order;
//    rst asserted mid-WAIT -> all outputs 0 at once.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the EX-stage MUL/DIV issuer.
// This covers the instruction codes seen in EX and the issuer FSM encodings.
package multi_cycle_ctrl_pkg;

    localparam logic [7:0] INST_NOP   = 8'h00;
    localparam logic [7:0] INST_MULT  = 8'h18;
    localparam logic [7:0] INST_MULTU = 8'h19;
    localparam logic [7:0] INST_DIV   = 8'h1A;
    localparam logic [7:0] INST_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_WAIT   = 2'd1,
        MC_COMMIT = 2'd2
    } mc_state_e;

    function automatic logic is_mc_inst(input logic [7:0] inst);
        return (inst == INST_MULT) || (inst == INST_MULTU) ||
               (inst == INST_DIV)  || (inst == INST_DIVU);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// EX-stage issuer for the MUL/DIV unit. It launches the unit, stalls IF..EX until
// the result arrives, and then writes {HI,LO}. A flush or the watchdog aborts the operation.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [7:0]  ex_inst,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        flush,
    output logic        stall_req,
    output logic        mc_start,
    output logic [7:0]  mc_inst,
    output logic [31:0] mc_op1,
    output logic [31:0] mc_op2,
    output logic        mc_abort,
    input  logic        mc_done,
    input  logic [63:0] mc_result,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        mc_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mc_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [7:0]        inst_nxt;
    logic [31:0]       op1_nxt, op2_nxt;
    logic [63:0]       wdata_nxt;
    logic              start_nxt, abort_nxt, timeout_nxt;
    logic              launch;

    assign launch    = (state == MC_IDLE) && ex_valid && is_mc_inst(ex_inst) && !flush;
    assign stall_req = launch || (state == MC_WAIT);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        inst_nxt    = mc_inst;
        op1_nxt     = mc_op1;
        op2_nxt     = mc_op2;
        wdata_nxt   = hilo_wdata;
        start_nxt   = 1'b0;
        abort_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        hilo_we     = 1'b0;
        case (state)
            MC_IDLE: begin
                if (launch) begin
                    inst_nxt  = ex_inst;
                    op1_nxt   = ex_op1;
                    op2_nxt   = ex_op2;
                    cnt_nxt   = '0;
                    start_nxt = 1'b1;
                    state_nxt = MC_WAIT;
                end
            end
            MC_WAIT: begin
                cnt_nxt = cnt + 1'b1;
                // A flush beats a coincident done: the instruction is squashed.
                if (flush) begin
                    abort_nxt = 1'b1;
                    inst_nxt  = INST_NOP;
                    state_nxt = MC_IDLE;
                end else if (mc_done) begin
                    wdata_nxt = mc_result;
                    state_nxt = MC_COMMIT;
                end else if (cnt == CNT_LAST) begin
                    abort_nxt   = 1'b1;
                    timeout_nxt = 1'b1;
                    inst_nxt    = INST_NOP;
                    state_nxt   = MC_IDLE;
                end
            end
            MC_COMMIT: begin
                // The EX instruction retires here. No relaunch happens until the FSM is back in IDLE.
                hilo_we   = !flush;
                inst_nxt  = INST_NOP;
                state_nxt = MC_IDLE;
            end
            default: begin
                inst_nxt  = INST_NOP;
                state_nxt = MC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MC_IDLE;
            cnt        <= '0;
            mc_inst    <= INST_NOP;
            mc_op1     <= '0;
            mc_op2     <= '0;
            hilo_wdata <= '0;
            mc_start   <= 1'b0;
            mc_abort   <= 1'b0;
            mc_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mc_inst    <= inst_nxt;
            mc_op1     <= op1_nxt;
            mc_op2     <= op2_nxt;
            hilo_wdata <= wdata_nxt;
            mc_start   <= start_nxt;
            mc_abort   <= abort_nxt;
            mc_timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl. Stimulus queues the expected start, abort and
// write events with their cycle numbers, and a negedge monitor pops and compares them.
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [7:0]  ex_inst;
    logic [31:0] ex_op1, ex_op2;
    logic        flush;
    logic        stall_req, mc_start, mc_abort, hilo_we, mc_timeout;
    logic [7:0]  mc_inst;
    logic [31:0] mc_op1, mc_op2;
    logic        mc_done;
    logic [63:0] mc_result, hilo_wdata;

    multi_cycle_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .flush(flush), .stall_req(stall_req),
        .mc_start(mc_start), .mc_inst(mc_inst), .mc_op1(mc_op1), .mc_op2(mc_op2),
        .mc_abort(mc_abort), .mc_done(mc_done), .mc_result(mc_result),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .mc_timeout(mc_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [71:0] val;
    } ev_t;

    ev_t start_q[$];
    ev_t wr_q[$];
    ev_t ab_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  stall_cycles = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        $display("FAIL %s: event at cycle %0d, none expected", name, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        ev_t e;
        if (stall_req) stall_cycles++;
        if (mc_start) begin
            if (start_q.size() == 0) unexpected("start_unexpected");
            else begin
                e = start_q.pop_front();
                check("start_cycle", 72'(cyc), 72'(e.cyc));
                check("start_req", {mc_inst, mc_op1, mc_op2}, e.val);
            end
        end
        if (mc_abort) begin
            if (ab_q.size() == 0) unexpected("abort_unexpected");
            else begin
                e = ab_q.pop_front();
                check("abort_cycle", 72'(cyc), 72'(e.cyc));
                check("abort_timeout", 72'(mc_timeout), e.val);
            end
        end else if (mc_timeout) unexpected("timeout_without_abort");
        if (hilo_we) begin
            if (wr_q.size() == 0) unexpected("write_unexpected");
            else begin
                e = wr_q.pop_front();
                check("write_cycle", 72'(cyc), 72'(e.cyc));
                check("write_data", {8'h0, hilo_wdata}, e.val);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        ex_valid = 1'b0; ex_inst = INST_NOP; ex_op1 = '0; ex_op2 = '0;
        flush = 1'b0; mc_done = 1'b0; mc_result = '0;
    endtask

    // Present an mc instruction in EX at the current cycle L. The FSM is expected to be idle.
    task automatic issue(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1; ex_inst = inst; ex_op1 = a; ex_op2 = b;
        stall_cycles = 0;
        start_q.push_back('{cyc + 1, {inst, a, b}});
    endtask

    // Raise done at L+lat, retire in COMMIT, and return with the FSM back in IDLE.
    task automatic complete(input int lat, input logic [63:0] res);
        repeat (lat) tick;
        mc_done = 1'b1; mc_result = res;
        wr_q.push_back('{cyc + 1, {8'h0, res}});
        tick;
        mc_done = 1'b0; ex_valid = 1'b0; ex_inst = INST_NOP;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_in;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 72'(stall_req), 72'(0));
        check("rst_start", 72'(mc_start), 72'(0));
        check("rst_inst", 72'(mc_inst), 72'(INST_NOP));
        check("rst_ops", {8'h0, mc_op1, mc_op2}, 72'(0));
        check("rst_wdata", 72'(hilo_wdata), 72'(0));
        check("rst_pulses", 72'({mc_abort, mc_timeout, hilo_we}), 72'(0));
        tick;
        rst = 1'b0;
        tick;

        // DIVU 100/7: the unit is done 36 cycles after launch
        issue(INST_DIVU, 32'd100, 32'd7);
        complete(36, {32'd2, 32'd14});
        check("divu_stall_cycles", 72'(stall_cycles), 72'(37));

        // MULT -3*5: the unit is done in the cycle after start
        issue(INST_MULT, 32'hFFFF_FFFD, 32'd5);
        complete(2, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mult_stall_cycles", 72'(stall_cycles), 72'(3));

        // flush 10 cycles into WAIT; a later done must be ignored
        issue(INST_DIV, 32'd50, 32'd5);
        repeat (10) tick;
        flush = 1'b1; ex_valid = 1'b0;
        ab_q.push_back('{cyc + 1, 72'(0)});
        tick;
        flush = 1'b0;
        @(negedge clk);
        check("flush_stall_drop", 72'(stall_req), 72'(0));
        check("flush_inst_nop", 72'(mc_inst), 72'(INST_NOP));
        check("flush_stall_cycles", 72'(stall_cycles), 72'(11));
        tick;
        mc_done = 1'b1; mc_result = 64'hDEAD_BEEF_0000_0001;
        tick;
        mc_done = 1'b0;
        tick;

        // done and flush in the same cycle: the flush wins
        issue(INST_MULTU, 32'd7, 32'd9);
        repeat (3) tick;
        mc_done = 1'b1; mc_result = 64'd63; flush = 1'b1; ex_valid = 1'b0;
        ab_q.push_back('{cyc + 1, 72'(0)});
        tick;
        mc_done = 1'b0; flush = 1'b0;
        repeat (2) tick;

        // flush during COMMIT squashes the write
        issue(INST_DIV, 32'd9, 32'd2);
        repeat (4) tick;
        mc_done = 1'b1; mc_result = {32'd1, 32'd4};
        tick;
        mc_done = 1'b0; flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        check("commit_flush_we", 72'(hilo_we), 72'(0));
        tick;
        flush = 1'b0;
        tick;

        // watchdog: no done, so the FSM aborts after 64 WAIT cycles
        issue(INST_MULT, 32'd1, 32'd2);
        ab_q.push_back('{cyc + 65, 72'(1)});
        tick;
        ex_valid = 1'b0;
        repeat (64) tick;
        @(negedge clk);
        check("timeout_stall_drop", 72'(stall_req), 72'(0));
        check("timeout_stall_cycles", 72'(stall_cycles), 72'(65));
        tick;

        // DIV then DIVU back-to-back; the DIVU is already visible in EX during COMMIT
        issue(INST_DIV, 32'hFFFF_FFEC, 32'd3);
        repeat (3) tick;
        mc_done = 1'b1; mc_result = {32'hFFFF_FFFE, 32'hFFFF_FFFA};
        wr_q.push_back('{cyc + 1, {8'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFA}});
        tick;
        mc_done = 1'b0;
        ex_inst = INST_DIVU; ex_op1 = 32'd100; ex_op2 = 32'd9;
        start_q.push_back('{cyc + 2, {INST_DIVU, 32'd100, 32'd9}});
        tick;
        repeat (3) tick;
        mc_done = 1'b1; mc_result = {32'd1, 32'd11};
        wr_q.push_back('{cyc + 1, {8'h0, 32'd1, 32'd11}});
        tick;
        mc_done = 1'b0; ex_valid = 1'b0; ex_inst = INST_NOP;
        tick;

        // IDLE: a non-mc inst, a flushed mc inst and a stray done all do nothing
        ex_valid = 1'b1; ex_inst = 8'h20;
        @(negedge clk);
        check("nonmc_no_stall", 72'(stall_req), 72'(0));
        tick;
        ex_inst = INST_DIV; flush = 1'b1;
        @(negedge clk);
        check("flushed_no_stall", 72'(stall_req), 72'(0));
        tick;
        flush = 1'b0; ex_valid = 1'b0; mc_done = 1'b1; mc_result = 64'h1234;
        tick;
        mc_done = 1'b0;
        tick;

        // async reset mid-WAIT clears everything at once
        issue(INST_MULTU, 32'd3, 32'd4);
        repeat (5) tick;
        rst = 1'b1; ex_valid = 1'b0;
        #1;
        check("arst_stall", 72'(stall_req), 72'(0));
        check("arst_inst", 72'(mc_inst), 72'(INST_NOP));
        check("arst_ops", {8'h0, mc_op1, mc_op2}, 72'(0));
        check("arst_wdata", 72'(hilo_wdata), 72'(0));
        check("arst_pulses", 72'({mc_start, mc_abort, mc_timeout, hilo_we}), 72'(0));
        repeat (2) tick;
        rst = 1'b0;
        repeat (4) tick;

        check("start_q_drained", 72'(start_q.size()), 72'(0));
        check("write_q_drained", 72'(wr_q.size()), 72'(0));
        check("abort_q_drained", 72'(ab_q.size()), 72'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
